// File: rtl/router_pkg.sv
// Constants shared by the 1x4 router, its per-port egress FIFOs and their benches.
package router_pkg;
  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [1:0] PORT0 = 2'b00;
  localparam logic [1:0] PORT1 = 2'b01;
  localparam logic [1:0] PORT2 = 2'b10;
  localparam logic [1:0] PORT3 = 2'b11;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module router_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/router_out_fifo.sv
// Per-port egress FWFT FIFO behind the router; converts valid pulses to valid/ready.
// Optional occupancy statistics (pkt_count, hwm) when ROUTER_FIFO_STATS_EN is defined.
module router_out_fifo
  import router_pkg::*;
#(
  parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int  DEPTH      = 8,
  localparam int AW         = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AW:0]           count,
  output logic                  overflow
`ifdef ROUTER_FIFO_STATS_EN
  ,
  output logic [15:0]           pkt_count,
  output logic [AW:0]           hwm
`endif
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] RDY_MAX  = (AW+1)'(DEPTH-2);

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full, pop, push, drop;

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop frees the head slot in the same edge, so a full FIFO can still take a beat.
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;
  // Two free slots: one beat already in the router's output register, one accepted now.
  assign in_ready  = (count <= RDY_MAX);
  assign out_data  = out_valid ? rdata : '0;

  router_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push && rst_n),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef ROUTER_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count <= '0;
      hwm       <= '0;
    end else begin
      if (push && pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
      if (count > hwm) hwm <= count;
    end
  end
`endif
endmodule

// File: tb/tb_router_out_fifo.sv
// Directed bench for router_out_fifo at DEPTH=4, including a modelled router feeding it.
module tb_router_out_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   count;
  logic          overflow;
`ifdef ROUTER_FIFO_STATS_EN
  logic [15:0]   pkt_count;
  logic [AW:0]   hwm;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  router_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count),
    .overflow (overflow)
`ifdef ROUTER_FIFO_STATS_EN
    ,
    .pkt_count(pkt_count),
    .hwm      (hwm)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_beat(input logic [7:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got %h want 00", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_fill_drain;
    logic [7:0] exp [3];
    exp[0] = 8'hA1; exp[1] = 8'hA2; exp[2] = 8'hA3;
    do_reset();
    push_beat(8'hA1);
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL fill_count1 got %0d want 1", count); end
    n_cmp++; if (out_data !== 8'hA1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL fill_fwft got %h/%b want a1/1", out_data, out_valid); end
    push_beat(8'hA2);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready_at2 got %b want 1", in_ready); end
    push_beat(8'hA3);
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL fill_count3 got %0d want 3", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready_at3 got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_data !== exp[i] || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL drain_%0d got %h/%b want %h/1", i, out_data, out_valid, exp[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty got %0d/%b want 0/0", count, out_valid); end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < 4; i++) push_beat(8'h10 + 8'(i));
    n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL ovf_full_count got %0d want 4", count); end
    push_beat(8'hFF);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", overflow); end
    n_cmp++; if (count !== 3'd4 || out_data !== 8'h10) begin n_bad++; $display("FAIL ovf_drop got %0d/%h want 4/10", count, out_data); end
    tick(); tick();
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end

    do_reset();
    for (int i = 0; i < 4; i++) push_beat(8'h10 + 8'(i));
    out_ready = 1'b1;
    push_beat(8'hFF);
    out_ready = 1'b0;
    n_cmp++; if (count !== 3'd4 || overflow !== 1'b0) begin n_bad++; $display("FAIL full_pushpop got %0d/%b want 4/0", count, overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = (i == 3) ? 8'hFF : 8'h11 + 8'(i);
      n_cmp++;
      if (out_data !== e) begin n_bad++; $display("FAIL full_pushpop_order_%0d got %h want %h", i, out_data, e); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  // Router model: beat accepted while in_ready is high shows up as a one-cycle pulse next cycle.
  task automatic test_stream;
    logic [7:0] exp_q [$];
    logic       rv, nv;
    logic [7:0] rd, nd;
    int sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0; rv = 1'b0; rd = '0; nd = '0;
    do_reset();
    while ((sent < 200 || rcvd < sent) && cyc < 3000) begin
      in_valid  = rv;
      in_data   = rd;
      out_ready = ($urandom_range(0, 3) != 0);
      nv = (sent < 200) && in_ready;
      if (nv) begin
        nd = 8'(sent) ^ 8'h5A;
        exp_q.push_back(nd);
        sent++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL stream_extra got %h want none", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            n_bad++; $display("FAIL stream_beat_%0d got %h want %h", rcvd, out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        rcvd++;
      end
      tick();
      rv = nv; rd = nd; cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (cyc >= 3000) begin n_bad++; $display("FAIL stream_timeout got %0d cycles want <3000", cyc); end
    n_cmp++; if (rcvd != 200) begin n_bad++; $display("FAIL stream_rcvd got %0d want 200", rcvd); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL stream_overflow got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 3; i++) push_beat(8'hC0 + 8'(i));
    n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL mid_pre_count got %0d want 3", count); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL mid_reset got %0d/%b/%b want 0/0/1", count, out_valid, in_ready);
    end
  endtask

`ifdef ROUTER_FIFO_STATS_EN
  task automatic test_stats;
    do_reset();
    n_cmp++; if (pkt_count !== 16'd0 || hwm !== 3'd0) begin n_bad++; $display("FAIL stats_reset got %0d/%0d want 0/0", pkt_count, hwm); end
    for (int i = 0; i < 3; i++) push_beat(8'hE0 + 8'(i));
    out_ready = 1'b1;
    push_beat(8'hE3);
    push_beat(8'hE4);
    tick(); tick(); tick(); tick();
    out_ready = 1'b0;
    n_cmp++; if (pkt_count !== 16'd5) begin n_bad++; $display("FAIL stats_pkt got %0d want 5", pkt_count); end
    n_cmp++; if (hwm !== 3'd3) begin n_bad++; $display("FAIL stats_hwm got %0d want 3", hwm); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_stream();
    test_reset_mid();
`ifdef ROUTER_FIFO_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
